// File: rtl/seq_det_pkg.sv
// Shared types and helpers for the parametrised sequence detector.
package seq_det_pkg;

  localparam int unsigned MASK_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    HUNT = 2'd2,
    HIT  = 2'd3
  } state_t;

  // Low 'len' bits set; callers truncate to their pattern width.
  function automatic logic [MASK_W-1:0] len_mask(input int unsigned len);
    if (len >= MASK_W) return '1;
    return (MASK_W'(1) << len) - MASK_W'(1);
  endfunction

endpackage

// File: rtl/seq_det_shreg_cmp.sv
// History shift register with synchronous clear and a masked pattern comparator.
// match_c is evaluated on the next history value so a hit registers on the same edge.
module seq_det_shreg_cmp #(
  parameter int unsigned MAX_LEN = 8
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               clr_i,
  input  logic               shift_i,
  input  logic               bit_i,
  input  logic [MAX_LEN-1:0] pat_i,
  input  logic [MAX_LEN-1:0] mask_i,
  output logic               match_c
);

  logic [MAX_LEN-1:0] hist_q, hist_d;

  // Clear first so a bit shifted on the same edge becomes the first held bit.
  always_comb begin
    hist_d = hist_q;
    if (clr_i) hist_d = '0;
    if (shift_i) hist_d = {hist_d[MAX_LEN-2:0], bit_i};
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) hist_q <= '0;
    else       hist_q <= hist_d;
  end

  assign match_c = (((hist_d ^ pat_i) & mask_i) == '0);

endmodule

// File: rtl/seq_detector_param.sv
// Moore detector for a runtime-programmable 1..MAX_LEN bit pattern, overlap selectable.
// Optional saturating match counter when SEQ_DET_MATCH_CNT_EN is defined.
module seq_detector_param
  import seq_det_pkg::*;
#(
  parameter int unsigned MAX_LEN = 8,
  parameter int unsigned LEN_W   = $clog2(MAX_LEN + 1)
`ifdef SEQ_DET_MATCH_CNT_EN
  , parameter int unsigned CNT_W = 16
`endif
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               en,
  input  logic [MAX_LEN-1:0] pat,
  input  logic [LEN_W-1:0]   pat_len,
  input  logic               overlap,
  input  logic               in_valid,
  input  logic               in,
  output logic               detected,
  output logic [1:0]         prs_st,
  output logic               cfg_err
`ifdef SEQ_DET_MATCH_CNT_EN
  , input  logic             cnt_clr,
  output logic [CNT_W-1:0]   match_cnt
`endif
);

  state_t             state_q, state_d;
  logic [LEN_W-1:0]   cnt_q, cnt_d;
  logic [MAX_LEN-1:0] pat_q, pat_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic               ovl_q, ovl_d;
  logic               detected_q, cfg_err_q, cfg_err_d;
  logic               clr, shift, match_c, len_ok, fill_done;
  logic [MAX_LEN-1:0] mask;

  assign len_ok    = (pat_len != '0) && (32'(pat_len) <= MAX_LEN);
  assign mask      = MAX_LEN'(len_mask(32'(len_q)));
  assign fill_done = ((LEN_W+1)'(cnt_q) + (LEN_W+1)'(1)) >= (LEN_W+1)'(len_q);

  seq_det_shreg_cmp #(.MAX_LEN(MAX_LEN)) u_shreg (
    .clk     (clk),
    .rstn    (rstn),
    .clr_i   (clr),
    .shift_i (shift),
    .bit_i   (in),
    .pat_i   (pat_q),
    .mask_i  (mask),
    .match_c (match_c)
  );

  // Next-state, fill count, config latch and history control.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pat_d     = pat_q;
    len_d     = len_q;
    ovl_d     = ovl_q;
    clr       = 1'b0;
    shift     = 1'b0;
    cfg_err_d = 1'b0;
    if (!en) begin
      state_d = IDLE;
      cnt_d   = '0;
      clr     = 1'b1;
    end else begin
      unique case (state_q)
        IDLE: begin
          pat_d     = pat;
          len_d     = pat_len;
          ovl_d     = overlap;
          cnt_d     = '0;
          cfg_err_d = !len_ok;
          if (len_ok) state_d = FILL;
        end
        FILL: begin
          if (in_valid) begin
            shift = 1'b1;
            cnt_d = cnt_q + LEN_W'(1);
            if (fill_done) state_d = match_c ? HIT : HUNT;
          end
        end
        HUNT: begin
          if (in_valid) begin
            shift = 1'b1;
            if (match_c) state_d = HIT;
          end
        end
        HIT: begin
          if (in_valid) begin
            shift = 1'b1;
            if (ovl_q) begin
              state_d = match_c ? HIT : HUNT;
            end else begin
              clr     = 1'b1;
              cnt_d   = LEN_W'(1);
              state_d = (len_q == LEN_W'(1) && match_c) ? HIT : FILL;
            end
          end else if (ovl_q) begin
            state_d = HUNT;
          end else begin
            clr     = 1'b1;
            cnt_d   = '0;
            state_d = FILL;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      pat_q      <= '0;
      len_q      <= '0;
      ovl_q      <= 1'b0;
      detected_q <= 1'b0;
      cfg_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      pat_q      <= pat_d;
      len_q      <= len_d;
      ovl_q      <= ovl_d;
      detected_q <= (state_d == HIT);
      cfg_err_q  <= cfg_err_d;
    end
  end

  assign detected = detected_q;
  assign cfg_err  = cfg_err_q;
  assign prs_st   = state_q;

`ifdef SEQ_DET_MATCH_CNT_EN
  logic [CNT_W-1:0] match_cnt_q;

  // Counts every entry into HIT, saturating; clear wins.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)                                          match_cnt_q <= '0;
    else if (cnt_clr)                                   match_cnt_q <= '0;
    else if (state_d == HIT && match_cnt_q != '1)       match_cnt_q <= match_cnt_q + CNT_W'(1);
  end

  assign match_cnt = match_cnt_q;
`endif

endmodule

// File: tb/tb_seq_detector_param.sv
// Directed bench for seq_detector_param; counter checks run when SEQ_DET_MATCH_CNT_EN is defined.
module tb_seq_detector_param;

  localparam int unsigned MAX_LEN = 8;
  localparam int unsigned LEN_W   = $clog2(MAX_LEN + 1);

  logic               clk = 1'b0;
  logic               rstn;
  logic               en;
  logic [MAX_LEN-1:0] pat;
  logic [LEN_W-1:0]   pat_len;
  logic               overlap;
  logic               in_valid;
  logic               in_b;
  logic               detected;
  logic [1:0]         prs_st;
  logic               cfg_err;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

`ifdef SEQ_DET_MATCH_CNT_EN
  logic       cnt_clr;
  logic [1:0] match_cnt;

  seq_detector_param #(.MAX_LEN(MAX_LEN), .CNT_W(2)) dut (
    .clk(clk), .rstn(rstn), .en(en), .pat(pat), .pat_len(pat_len),
    .overlap(overlap), .in_valid(in_valid), .in(in_b), .detected(detected),
    .prs_st(prs_st), .cfg_err(cfg_err), .cnt_clr(cnt_clr), .match_cnt(match_cnt)
  );
`else
  seq_detector_param #(.MAX_LEN(MAX_LEN)) dut (
    .clk(clk), .rstn(rstn), .en(en), .pat(pat), .pat_len(pat_len),
    .overlap(overlap), .in_valid(in_valid), .in(in_b), .detected(detected),
    .prs_st(prs_st), .cfg_err(cfg_err)
  );
`endif

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Go through IDLE, latch a new config and land in FILL.
  task automatic start_cfg(input logic [MAX_LEN-1:0] p, input logic [LEN_W-1:0] l, input logic o);
    @(negedge clk);
    en = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    pat = p; pat_len = l; overlap = o; en = 1'b1;
    @(posedge clk); #1;
    check("cfg_to_fill", 32'(prs_st), 32'd1);
  endtask

  // Bits given MSB-first in the low n positions; exp marks bits that must raise detected.
  task automatic stream(input string tag, input logic [15:0] bits, input logic [15:0] exp,
                        input int n, input bit gaps);
    for (int i = n - 1; i >= 0; i--) begin
      if (gaps) begin
        @(negedge clk);
        in_valid = 1'b0; in_b = 1'b1;
        @(posedge clk); #1;
        check({tag, "_gap"}, 32'(detected), 32'd0);
      end
      @(negedge clk);
      in_valid = 1'b1; in_b = bits[i];
      @(posedge clk); #1;
      check(tag, 32'(detected), 32'(exp[i]));
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  initial begin
    rstn = 1'b0; en = 1'b0; pat = '0; pat_len = '0; overlap = 1'b0;
    in_valid = 1'b0; in_b = 1'b0;
`ifdef SEQ_DET_MATCH_CNT_EN
    cnt_clr = 1'b0;
`endif
    #12;
    check("rst_detected", 32'(detected), 32'd0);
    check("rst_prs_st",   32'(prs_st),   32'd0);
    check("rst_cfg_err",  32'(cfg_err),  32'd0);
    @(negedge clk);
    rstn = 1'b1;

    // T1 / T2: 1011 over 1,0,1,1,0,1,1
    start_cfg(8'b0000_1011, LEN_W'(4), 1'b0);
    stream("t1_novl", 16'b1011011, 16'b0001000, 7, 1'b0);
    start_cfg(8'b0000_1011, LEN_W'(4), 1'b1);
    stream("t2_ovl",  16'b1011011, 16'b0001001, 7, 1'b0);

    // T3: 111 with junk above pat_len to exercise masking
    start_cfg(8'b1010_0111, LEN_W'(3), 1'b1);
    stream("t3_ovl",  16'b11111,  16'b00111,  5, 1'b0);
    start_cfg(8'b1010_0111, LEN_W'(3), 1'b0);
    stream("t3_novl", 16'b111111, 16'b001001, 6, 1'b0);

    // T4: T1 with an ignored in=1 gap cycle before every bit
    start_cfg(8'b0000_1011, LEN_W'(4), 1'b0);
    stream("t4_gaps", 16'b1011011, 16'b0001000, 7, 1'b1);

    // Single-bit pattern, non-overlap back-to-back hits
    start_cfg(8'b0000_0001, LEN_W'(1), 1'b0);
    stream("len1", 16'b1101, 16'b1101, 4, 1'b0);

    // T5: en drop clears partial history
    start_cfg(8'b0000_1011, LEN_W'(4), 1'b0);
    stream("t5_pre", 16'b101, 16'b000, 3, 1'b0);
    @(negedge clk);
    en = 1'b0;
    @(posedge clk); #1;
    check("t5_en0_state", 32'(prs_st),   32'd0);
    check("t5_en0_det",   32'(detected), 32'd0);
    @(negedge clk);
    en = 1'b1;
    @(posedge clk); #1;
    check("t5_refill", 32'(prs_st), 32'd1);
    stream("t5_post", 16'b11011, 16'b00001, 5, 1'b0);

    // T5: reset while detected is high
    start_cfg(8'b0000_1011, LEN_W'(4), 1'b1);
    stream("t5_hit", 16'b1011, 16'b0001, 4, 1'b0);
    @(posedge clk); #1;
    check("t5_hold_state", 32'(prs_st), 32'd2);
    start_cfg(8'b0000_1011, LEN_W'(4), 1'b1);
    stream("t5_hit2", 16'b1011, 16'b0001, 4, 1'b0);
    #0;
    @(posedge clk); #1;
    @(negedge clk);
    in_valid = 1'b1; in_b = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    start_cfg(8'b0000_1011, LEN_W'(4), 1'b0);
    for (int i = 3; i >= 0; i--) begin
      @(negedge clk);
      in_valid = 1'b1; in_b = (i == 2) ? 1'b0 : 1'b1;
      @(posedge clk); #1;
    end
    check("t5_prerst_det", 32'(detected), 32'd1);
    #2 rstn = 1'b0;
    #1;
    check("t5_rst_det",   32'(detected), 32'd0);
    check("t5_rst_state", 32'(prs_st),   32'd0);
    check("t5_rst_err",   32'(cfg_err),  32'd0);
    @(negedge clk);
    rstn = 1'b1; in_valid = 1'b0;

    // T6: illegal lengths stay in IDLE with cfg_err
    start_cfg(8'b0000_1011, LEN_W'(4), 1'b0);
    @(negedge clk);
    en = 1'b0;
    @(negedge clk);
    pat_len = LEN_W'(0); en = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("t6_len0_state", 32'(prs_st),  32'd0);
    check("t6_len0_err",   32'(cfg_err), 32'd1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      in_valid = 1'b1; in_b = 1'b1;
      @(posedge clk); #1;
      check("t6_len0_det", 32'(detected), 32'd0);
    end
    @(negedge clk);
    pat_len = LEN_W'(MAX_LEN + 1);
    repeat (2) @(posedge clk);
    #1;
    check("t6_len9_state", 32'(prs_st),  32'd0);
    check("t6_len9_err",   32'(cfg_err), 32'd1);
    check("t6_len9_det",   32'(detected), 32'd0);
    @(negedge clk);
    en = 1'b0; in_valid = 1'b0;
    @(posedge clk); #1;
    check("t6_en0_err", 32'(cfg_err), 32'd0);

`ifdef SEQ_DET_MATCH_CNT_EN
    @(negedge clk);
    cnt_clr = 1'b1;
    @(negedge clk);
    cnt_clr = 1'b0;
    check("cnt_clr0", 32'(match_cnt), 32'd0);
    start_cfg(8'b0000_0001, LEN_W'(1), 1'b1);
    stream("cnt_hits", 16'b11111, 16'b11111, 5, 1'b0);
    check("cnt_sat", 32'(match_cnt), 32'd3);
    @(negedge clk);
    cnt_clr = 1'b1;
    @(posedge clk); #1;
    check("cnt_clr", 32'(match_cnt), 32'd0);
    cnt_clr = 1'b0;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
